// File: rtl/jtframe_i2s_rx.sv
// jtframe_i2s_rx: oversampled Philips I2S receiver, parallel L/R out.
// Optional watchdog: define JTFRAME_I2S_RX_TIMEOUT_EN.
module jtframe_i2s_rx #(
    parameter int DW  = 16,
    parameter int TOW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i2s_bclk,
    input  logic          i2s_lrck,
    input  logic          i2s_data,
    output logic [DW-1:0] left,
    output logic [DW-1:0] right,
    output logic          sample,
    output logic          locked,
    output logic          short_err
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SKIPL,
        ST_RX
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic r_bclk_m;
    logic r_bclk_s;
    logic r_bclk_d;
    logic r_lrck_m;
    logic r_lrck_s;
    logic r_data_m;
    logic r_data_s;

    logic          r_lr_prev;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_shreg;
    logic [DW-1:0] r_pend;
    logic          r_pend_v;

    logic          w_rise;
    logic          w_flip;
    logic          w_room;
    logic          w_short;
    logic [CW-1:0] w_n;
    logic [CW-1:0] w_pad;
    logic [DW-1:0] w_shift;
    logic [DW-1:0] w_word;
    logic          w_cap_l;
    logic          w_cap_r;
    logic          w_tout;

    // Pins are asynchronous; sync flops just follow them, no reset needed.
    always_ff @(posedge clk) begin
        r_bclk_m <= i2s_bclk;
        r_bclk_s <= r_bclk_m;
        r_bclk_d <= r_bclk_s;
        r_lrck_m <= i2s_lrck;
        r_lrck_s <= r_lrck_m;
        r_data_m <= i2s_data;
        r_data_s <= r_data_m;
    end

    assign w_rise  = r_bclk_s & ~r_bclk_d;
    assign w_flip  = w_rise & (r_lrck_s != r_lr_prev);
    assign w_room  = r_cnt < CW'(DW);
    assign w_short = r_cnt < CW'(DW - 1);
    assign w_shift = w_room ? {r_shreg[DW-2:0], r_data_s} : r_shreg;
    assign w_n     = w_room ? r_cnt + CW'(1) : CW'(DW);
    assign w_pad   = CW'(DW) - w_n;
    assign w_word  = w_shift << w_pad;
    assign w_cap_l = w_flip & ~r_lr_prev & (r_state == ST_RX);
    assign w_cap_r = w_flip & r_lr_prev & (r_state == ST_RX) & r_pend_v;

`ifdef JTFRAME_I2S_RX_TIMEOUT_EN
    logic [TOW-1:0] r_wd;

    // Cycles since the last BCLK rise; an edge always wins over expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd <= '0;
        end else if (w_rise) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + TOW'(1);
        end
    end

    assign w_tout = (&r_wd) & ~w_rise;
`else
    logic w_unused_tow;

    assign w_unused_tow = (TOW > 0);
    assign w_tout       = 1'b0;
`endif

    // Lock state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // HUNT waits for a right->left change, SKIPL drops one left word.
    always_comb begin
        w_state_nx = r_state;
        if (w_tout) begin
            w_state_nx = ST_HUNT;
        end else if (w_flip) begin
            unique case (r_state)
                ST_HUNT: begin
                    if (r_lr_prev) begin
                        w_state_nx = ST_SKIPL;
                    end
                end
                ST_SKIPL: w_state_nx = ST_RX;
                ST_RX:    w_state_nx = ST_RX;
                default:  w_state_nx = ST_HUNT;
            endcase
        end
    end

    // Bit shifting, word completion and sample hand-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lr_prev <= 1'b0;
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_pend    <= '0;
            r_pend_v  <= 1'b0;
            left      <= '0;
            right     <= '0;
            sample    <= 1'b0;
            locked    <= 1'b0;
            short_err <= 1'b0;
        end else begin
            sample    <= 1'b0;
            short_err <= 1'b0;
            if (w_rise) begin
                r_lr_prev <= r_lrck_s;
                r_shreg   <= w_shift;
                if (w_flip) begin
                    r_cnt     <= '0;
                    short_err <= w_short;
                end else if (w_room) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            if (w_cap_l) begin
                r_pend <= w_word;
            end
            if (r_state != ST_RX || w_tout) begin
                r_pend_v <= 1'b0;
            end else if (w_cap_l) begin
                r_pend_v <= 1'b1;
            end
            if (w_cap_r) begin
                left   <= r_pend;
                right  <= w_word;
                sample <= 1'b1;
                locked <= 1'b1;
            end
            if (w_tout) begin
                r_cnt  <= '0;
                locked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_i2s_rx.sv
// tb_jtframe_i2s_rx: random I2S streams against a word-level model.
// Build with JTFRAME_I2S_RX_TIMEOUT_EN to exercise the watchdog.
module tb_jtframe_i2s_rx;

    localparam int DW  = 16;
    localparam int TOW = 12;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          bclk = 1'b0;
    logic          lrck = 1'b0;
    logic          data = 1'b0;
    logic [DW-1:0] left;
    logic [DW-1:0] right;
    logic          sample;
    logic          locked;
    logic          short_err;

    jtframe_i2s_rx #(.DW(DW), .TOW(TOW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i2s_bclk  (bclk),
        .i2s_lrck  (lrck),
        .i2s_data  (data),
        .left      (left),
        .right     (right),
        .sample    (sample),
        .locked    (locked),
        .short_err (short_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            t;
    } smp_t;

    smp_t got_q[$];
    smp_t exp_q[$];
    int   got_short = 0;

    always @(negedge clk) begin
        if (sample) got_q.push_back('{left, right, cyc});
        if (short_err) got_short++;
    end

    // Word-level reference: a word ends on the edge where LRCK changes.
    int            m_prev;
    bit            m_bits[$];
    int            m_phase;
    logic [DW-1:0] m_pend;
    bit            m_pend_v;
    bit            m_locked;
    int            m_short = 0;
    logic [DW-1:0] m_last_l = '0;
    logic [DW-1:0] m_last_r = '0;

    function automatic void model_reset(input bit keep_prev);
        if (!keep_prev) m_prev = 0;
        m_bits.delete();
        m_phase  = 0;
        m_pend_v = 0;
        m_locked = 0;
    endfunction

    function automatic void model_edge(input bit lr, input bit d, input int t);
        logic [DW-1:0] w;
        int            n;
        m_bits.push_back(d);
        if (int'(lr) != m_prev) begin
            w = '0;
            n = m_bits.size();
            for (int k = 0; k < n && k < DW; k++) w[DW-1-k] = m_bits[k];
            if (n < DW) m_short++;
            if (m_prev == 0) begin
                if (m_phase == 1) m_phase = 2;
                else if (m_phase == 2) begin
                    m_pend   = w;
                    m_pend_v = 1;
                end
            end else begin
                if (m_phase == 0) m_phase = 1;
                else if (m_phase == 2 && m_pend_v) begin
                    exp_q.push_back('{m_pend, w, t + 3});
                    m_last_l = m_pend;
                    m_last_r = w;
                    m_locked = 1;
                end
            end
            m_bits.delete();
            m_prev = int'(lr);
        end
    endfunction

    bit q_ch[$];
    bit q_d[$];
    int last_rise = 0;

    task automatic add_slot(input bit ch, input int len, input logic [DW-1:0] w);
        for (int k = 0; k < len; k++) begin
            q_ch.push_back(ch);
            q_d.push_back(k < DW ? w[DW-1-k] : 1'($urandom));
        end
    endtask

    task automatic add_frame(input int s, input logic [DW-1:0] l,
                             input logic [DW-1:0] r);
        add_slot(1'b0, s, l);
        add_slot(1'b1, s, r);
    endtask

    // LRCK leads by one bit: it shows the next slot's channel on the LSB.
    task automatic play(input int h, input int rst_at);
        int n;
        bit lr;
        n = q_d.size();
        for (int i = 0; i < n; i++) begin
            lr   = (i + 1 < n) ? q_ch[i+1] : ~q_ch[i];
            bclk = 1'b0;
            lrck = lr;
            data = q_d[i];
            if (i == rst_at) begin
                @(posedge clk); #1 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                model_reset(1'b0);
                @(negedge clk);
                chk("rst_left", left, 0);
                chk("rst_right", right, 0);
                chk("rst_sample", sample, 0);
                chk("rst_locked", locked, 0);
                chk("rst_short", short_err, 0);
            end
            repeat (h) @(posedge clk);
            #1 bclk = 1'b1;
            last_rise = cyc;
            model_edge(lr, q_d[i], cyc);
            repeat (h) @(posedge clk);
            #1;
        end
        bclk = 1'b0;
        q_ch.delete();
        q_d.delete();
    endtask

    task automatic check_seg(input string tag);
        smp_t g;
        smp_t e;
        int   d;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            d = g.t - e.t;
            chk({tag, "_left"}, g.l, e.l);
            chk({tag, "_right"}, g.r, e.r);
            chk({tag, "_lat"}, (d >= 0 && d <= 1), 1);
        end
        got_q.delete();
        exp_q.delete();
        chk({tag, "_short"}, got_short, m_short);
        chk({tag, "_locked"}, locked, m_locked);
    endtask

    initial begin
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            fall;

        model_reset(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_left", left, 0);
        chk("reset_right", right, 0);
        chk("reset_sample", sample, 0);
        chk("reset_locked", locked, 0);
        chk("reset_short", short_err, 0);
        #1 rst = 1'b0;

        for (int f = 0; f < 4; f++) add_frame(32, 16'h1234, 16'hABCD);
        for (int f = 0; f < 4; f++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            add_frame(32, a, b);
        end
        play($urandom_range(2, 3), -1);
        check_seg("slot32");

        for (int f = 0; f < 3; f++) begin
            add_frame(16, 16'h8001, 16'h7FFE);
            add_frame(16, 16'h0000, 16'hFFFF);
        end
        for (int f = 0; f < 3; f++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            add_frame(16, a, b);
        end
        play($urandom_range(2, 3), -1);
        check_seg("slot16");

        for (int f = 0; f < 2; f++) add_frame(12, 16'hABC0, 16'h1230);
        for (int f = 0; f < 2; f++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            add_frame(12, a, b);
        end
        play($urandom_range(2, 3), -1);
        check_seg("slot12");

        a = DW'($urandom);
        b = DW'($urandom);
        add_slot(1'b0, 200, a);
        add_slot(1'b1, 32, b);
        add_frame(32, 16'h5A5A, 16'hC3C3);
        play($urandom_range(2, 3), -1);
        check_seg("const_lr");

        for (int f = 0; f < 5; f++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            add_frame(32, a, b);
        end
        play($urandom_range(2, 3), 32 + 5);
        check_seg("midrst");

        fall = -1;
        for (int k = 0; k < 4300; k++) begin
            @(negedge clk);
            if (!locked && fall < 0) fall = cyc - last_rise;
        end
`ifdef JTFRAME_I2S_RX_TIMEOUT_EN
        chk("wd_fall", (fall >= 4096 && fall <= 4100), 1);
        model_reset(1'b1);
`else
        chk("wd_nofall", locked, 1);
`endif
        chk("wd_hold_left", left, m_last_l);
        chk("wd_hold_right", right, m_last_r);

        for (int f = 0; f < 4; f++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            add_frame(32, a, b);
        end
        play($urandom_range(2, 3), -1);
        check_seg("relock");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
